// File: rtl/pipe_regfile_sb_if.sv
// Bundled read/write/issue signals of the decode-stage register file.
// master drives addresses, write data and issue controls; slave returns read data and busy status.
interface pipe_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]      ra;
    logic [NREAD*DATA_W-1:0]  rd;
    logic [NREAD-1:0]         rd_busy;
    logic [NWRITE-1:0]        we;
    logic [NWRITE*AW-1:0]     wa;
    logic [NWRITE*DATA_W-1:0] wd;
    logic [DATA_W-1:0]        r15;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;
    logic [AW:0]              nbusy;

    modport master (
        output ra, we, wa, wd, r15, iss_en, iss_addr, flush,
        input  rd, rd_busy, nbusy
    );

    modport slave (
        input  ra, we, wa, wd, r15, iss_en, iss_addr, flush,
        output rd, rd_busy, nbusy
    );
endinterface

// File: rtl/pipe_regfile_sb.sv
// Decode-stage register file: multi-port writes with forwarding, PC alias at the top
// address, and a busy-bit scoreboard with a registered busy count.
module pipe_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input logic              clk,
    input logic              reset,
    pipe_regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int NS = NREGS - 1;
    localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

    logic [DATA_W-1:0] rf [NS];
    logic [NS-1:0]     busy;
    logic [NS-1:0]     busy_nxt;
    logic [AW:0]       nbusy_q;
    logic [AW:0]       nbusy_nxt;

    logic [NS-1:0]     wr_hit;
    logic [DATA_W-1:0] wr_data [NS];

    function automatic logic [AW:0] popcount(input logic [NS-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NS; i++) begin
            n = n + (AW+1)'(v[i]);
        end
        return n;
    endfunction

    // Per-register write resolution; later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        for (int r = 0; r < NS; r++) begin
            wr_hit[r]  = 1'b0;
            wr_data[r] = '0;
            for (int i = 0; i < NWRITE; i++) begin
                if (bus.we[i] && (bus.wa[i*AW +: AW] == AW'(r))) begin
                    wr_hit[r]  = 1'b1;
                    wr_data[r] = bus.wd[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NS; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NS; r++) begin
                if (wr_hit[r]) begin
                    rf[r] <= wr_data[r];
                end
            end
        end
    end

    // Issue outranks a same-cycle writeback: the new producer supersedes the retiring one.
    always_comb begin
        for (int r = 0; r < NS; r++) begin
            if (reset || bus.flush) begin
                busy_nxt[r] = 1'b0;
            end else if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_nxt[r] = 1'b0;
            end else begin
                busy_nxt[r] = busy[r];
            end
        end
        nbusy_nxt = popcount(busy_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= '0;
            nbusy_q <= '0;
        end else begin
            busy    <= busy_nxt;
            nbusy_q <= nbusy_nxt;
        end
    end

    assign bus.nbusy = nbusy_q;

    // Read ports: PC alias first, then forwarded write data, then storage.
    always_comb begin
        logic [AW-1:0]     addr;
        logic              fwd;
        logic [DATA_W-1:0] fwd_data;
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NREAD; p++) begin
            addr     = bus.ra[p*AW +: AW];
            fwd      = 1'b0;
            fwd_data = '0;
            for (int i = 0; i < NWRITE; i++) begin
                if (!reset && bus.we[i] && (bus.wa[i*AW +: AW] == addr)) begin
                    fwd      = 1'b1;
                    fwd_data = bus.wd[i*DATA_W +: DATA_W];
                end
            end
            if (addr == PC_ADDR) begin
                bus.rd[p*DATA_W +: DATA_W] = bus.r15;
                bus.rd_busy[p]             = 1'b0;
            end else if (fwd) begin
                bus.rd[p*DATA_W +: DATA_W] = fwd_data;
                bus.rd_busy[p]             = 1'b0;
            end else begin
                bus.rd[p*DATA_W +: DATA_W] = reset ? '0 : rf[addr];
                bus.rd_busy[p]             = !reset && busy[addr];
            end
        end
    end
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Directed, table-driven bench for pipe_regfile_sb (2 read ports, 2 write ports, 16 registers).
module tb_pipe_regfile_sb;
    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_regfile_sb_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();

    pipe_regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [3:0]  wa0;
        logic [31:0] wd0;
        logic [3:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic        iss;
        logic [3:0]  iss_addr;
        logic        flush;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [1:0]  exp_busy;
        logic [4:0]  exp_nbusy;
    } vec_t;

    vec_t vt [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] we, input logic [3:0] wa0,
                         input logic [31:0] wd0, input logic [3:0] wa1, input logic [31:0] wd1,
                         input logic [3:0] ra0, input logic [3:0] ra1, input logic iss,
                         input logic [3:0] ia, input logic fl);
        reset        = rst;
        bus.we       = we;
        bus.wa       = {wa1, wa0};
        bus.wd       = {wd1, wd0};
        bus.ra       = {ra1, ra0};
        bus.iss_en   = iss;
        bus.iss_addr = ia;
        bus.flush    = fl;
    endtask

    task automatic idle(input logic [3:0] ra0, input logic [3:0] ra1);
        drive(1'b0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, ra0, ra1, 1'b0, 4'd0, 1'b0);
    endtask

    function automatic vec_t mk(input logic rst, input logic [1:0] we, input logic [3:0] wa0,
                                input logic [31:0] wd0, input logic [3:0] wa1, input logic [31:0] wd1,
                                input logic [3:0] ra0, input logic [3:0] ra1, input logic iss,
                                input logic [3:0] ia, input logic fl, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [1:0] eb, input logic [4:0] en);
        vec_t v;
        v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.iss_addr = ia; v.flush = fl;
        v.exp_rd0 = e0; v.exp_rd1 = e1; v.exp_busy = eb; v.exp_nbusy = en;
        return v;
    endfunction

    initial begin
        // rst we  wa0 wd0 wa1 wd1 ra0 ra1 iss ia fl | rd0 rd1 busy nbusy(after edge)
        vt[0]  = mk(0, 2'b11, 3, 32'hAAAA_0001, 3, 32'h5555_0002, 3, 0, 0, 0, 0, 32'h5555_0002, 32'h0, 2'b00, 0);
        vt[1]  = mk(0, 2'b00, 0, 0, 0, 0, 3, 15, 0, 0, 0, 32'h5555_0002, 32'h40, 2'b00, 0);
        vt[2]  = mk(0, 2'b01, 15, 32'hDEAD_BEEF, 0, 0, 15, 3, 0, 0, 0, 32'h40, 32'h5555_0002, 2'b00, 0);
        vt[3]  = mk(0, 2'b00, 0, 0, 0, 0, 15, 14, 0, 0, 0, 32'h40, 32'h0, 2'b00, 0);
        vt[4]  = mk(0, 2'b00, 0, 0, 0, 0, 5, 3, 1, 5, 0, 32'h0, 32'h5555_0002, 2'b00, 1);
        vt[5]  = mk(0, 2'b00, 0, 0, 0, 0, 5, 5, 0, 0, 0, 32'h0, 32'h0, 2'b11, 1);
        vt[6]  = mk(0, 2'b01, 5, 32'h77, 0, 0, 5, 6, 0, 0, 0, 32'h77, 32'h0, 2'b00, 0);
        vt[7]  = mk(0, 2'b00, 0, 0, 0, 0, 5, 6, 0, 0, 0, 32'h77, 32'h0, 2'b00, 0);
        vt[8]  = mk(0, 2'b00, 0, 0, 0, 0, 7, 0, 1, 7, 0, 32'h0, 32'h0, 2'b00, 1);
        vt[9]  = mk(0, 2'b10, 0, 0, 7, 32'h99, 7, 7, 1, 7, 0, 32'h99, 32'h99, 2'b00, 1);
        vt[10] = mk(0, 2'b00, 0, 0, 0, 0, 7, 9, 0, 0, 0, 32'h99, 32'h0, 2'b01, 1);
        vt[11] = mk(0, 2'b00, 0, 0, 0, 0, 7, 3, 1, 3, 0, 32'h99, 32'h5555_0002, 2'b01, 2);
        vt[12] = mk(0, 2'b00, 0, 0, 0, 0, 7, 3, 1, 9, 1, 32'h99, 32'h5555_0002, 2'b11, 0);
        vt[13] = mk(0, 2'b00, 0, 0, 0, 0, 9, 7, 0, 0, 0, 32'h0, 32'h99, 2'b00, 0);
        vt[14] = mk(0, 2'b11, 1, 32'h11, 9, 32'h22, 1, 9, 0, 0, 0, 32'h11, 32'h22, 2'b00, 0);
        vt[15] = mk(0, 2'b00, 0, 0, 0, 0, 1, 9, 1, 1, 0, 32'h11, 32'h22, 2'b00, 1);
        vt[16] = mk(0, 2'b00, 0, 0, 0, 0, 1, 2, 1, 2, 0, 32'h11, 32'h0, 2'b01, 2);
        vt[17] = mk(0, 2'b00, 0, 0, 0, 0, 1, 2, 1, 4, 0, 32'h11, 32'h0, 2'b11, 3);
        vt[18] = mk(1, 2'b01, 1, 32'hFFFF, 0, 0, 1, 15, 1, 6, 0, 32'h0, 32'h40, 2'b00, 0);
        vt[19] = mk(0, 2'b00, 0, 0, 0, 0, 1, 4, 0, 0, 0, 32'h0, 32'h0, 2'b00, 0);

        // Reset, with a write attempted under reset that must neither forward nor store.
        bus.r15 = 32'h0000_1008;
        @(negedge clk);
        drive(1'b1, 2'b01, 4'd2, 32'h123, 4'd0, 32'h0, 4'd2, 4'd15, 1'b1, 4'd2, 1'b0);
        #1;
        check("reset rd0 no fwd", bus.rd[31:0], 32'h0);
        check("reset rd1 pc", bus.rd[63:32], 32'h0000_1008);
        @(posedge clk); #1;
        check("reset nbusy", 32'(bus.nbusy), 32'h0);

        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            idle(4'(a), 4'(NREGS - 1 - a));
            #1;
            check($sformatf("readall rd0 a%0d", a), bus.rd[31:0], (a == 15) ? 32'h0000_1008 : 32'h0);
            check($sformatf("readall rd1 a%0d", 15 - a), bus.rd[63:32], (a == 0) ? 32'h0000_1008 : 32'h0);
            check($sformatf("readall busy a%0d", a), 32'(bus.rd_busy), 32'h0);
            check($sformatf("readall nbusy a%0d", a), 32'(bus.nbusy), 32'h0);
        end

        bus.r15 = 32'h40;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].we, vt[i].wa0, vt[i].wd0, vt[i].wa1, vt[i].wd1,
                  vt[i].ra0, vt[i].ra1, vt[i].iss, vt[i].iss_addr, vt[i].flush);
            #1;
            check($sformatf("row%0d rd0", i), bus.rd[31:0], vt[i].exp_rd0);
            check($sformatf("row%0d rd1", i), bus.rd[63:32], vt[i].exp_rd1);
            check($sformatf("row%0d rd_busy", i), 32'(bus.rd_busy), 32'(vt[i].exp_busy));
            @(posedge clk); #1;
            check($sformatf("row%0d nbusy", i), 32'(bus.nbusy), 32'(vt[i].exp_nbusy));
        end

        // Issue every address including the PC alias; the alias never counts.
        for (int a = 0; a < NREGS; a++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0, 4'd15, 1'b1, 4'(a), 1'b0);
            @(posedge clk); #1;
            check($sformatf("fill nbusy a%0d", a), 32'(bus.nbusy), (a == 15) ? 32'd15 : 32'(a + 1));
        end
        @(negedge clk);
        idle(4'd14, 4'd15);
        #1;
        check("fill rd_busy", 32'(bus.rd_busy), 32'h1);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 4'd14, 4'd15, 1'b0, 4'd0, 1'b1);
        @(posedge clk); #1;
        check("flush nbusy", 32'(bus.nbusy), 32'h0);
        @(negedge clk);
        idle(4'd14, 4'd0);
        #1;
        check("flush rd_busy", 32'(bus.rd_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
